sampler_sweep_controller: RTL

- Sequences the MCMC proposal datapath over all variables for a programmed number of sweeps.
- Per variable: requests segment info from the segment-select stage, holds it stable on the Sampler inputs for the Sampler latency, then captures the proposed value and issues one write to the variable register file.
- Sits between segment selection, the Sampler, and the variable store; top-level control starts it and waits for done.

---
 rtl/sampler_sweep_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sampler_sweep_controller.sv
// Sweep controller for the MCMC proposal datapath.
// For each variable, it fetches segment info and holds it on the Sampler for
// SAMPLER_LAT cycles. It then captures the proposed value and issues one
// register-file write. This repeats for a programmed number of sweeps.
module sampler_sweep_controller #(
   parameter int unsigned NUM_VARS    = 4,
   parameter int unsigned IDX_W       = 2,
   parameter int unsigned SAMPLER_LAT = 2
) (
   input  logic                    in_clock,
   input  logic                    in_reset_n,
   input  logic                    in_start,
   input  logic                    in_abort,
   input  logic [7:0]              in_num_sweeps,
   output logic                    out_busy,
   output logic                    out_done,
   output logic                    out_seg_req,
   output logic [IDX_W-1:0]        out_seg_var_index,
   input  logic                    in_seg_valid,
   input  logic signed [7:0]       in_seg_from,
   input  logic signed [7:0]       in_seg_to,
   input  logic signed [7:0]       in_seg_weight,
   input  logic [1:0]              in_seg_type,
   output logic signed [7:0]       out_smp_from,
   output logic signed [7:0]       out_smp_to,
   output logic signed [7:0]       out_smp_weight,
   output logic [1:0]              out_smp_type,
   output logic                    out_smp_enable,
   input  logic signed [7:0]       in_smp_value,
   output logic                    out_wr_en,
   output logic [IDX_W-1:0]        out_wr_index,
   output logic signed [7:0]       out_wr_value,
   output logic [7:0]              out_sweep_count,
   output logic [7:0]              out_skip_count
);

   localparam int unsigned CntW = $clog2(SAMPLER_LAT + 1);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VARS - 1);
   localparam logic [CntW-1:0]  LatInit = CntW'(SAMPLER_LAT);

   typedef enum logic [2:0] {StIdle, StReq, StDrive, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        sweeps_q, sweeps_d;
   logic [7:0]        sweep_cnt_q, sweep_cnt_d;
   logic [7:0]        skip_cnt_q, skip_cnt_d;
   logic signed [7:0] smp_from_q, smp_from_d;
   logic signed [7:0] smp_to_q, smp_to_d;
   logic signed [7:0] smp_weight_q, smp_weight_d;
   logic [1:0]        smp_type_q, smp_type_d;
   logic [IDX_W-1:0]  wr_index_q, wr_index_d;
   logic signed [7:0] wr_value_q, wr_value_d;

   // Shared "advance to next variable" terms, used by WRITE and by skipped segments.
   logic              last_var;
   logic [7:0]        sweep_next;
   logic [IDX_W-1:0]  idx_next;
   state_e            adv_state;

   // Next-variable bookkeeping.
   always_comb begin
      last_var   = (idx_q == LastIdx);
      sweep_next = sweep_cnt_q + 8'd1;
      idx_next   = last_var ? '0 : idx_q + IDX_W'(1);
      adv_state  = (last_var && (sweep_next == sweeps_q)) ? StDone : StReq;
   end

   // State and datapath registers.
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         cnt_q        <= '0;
         sweeps_q     <= '0;
         sweep_cnt_q  <= '0;
         skip_cnt_q   <= '0;
         smp_from_q   <= '0;
         smp_to_q     <= '0;
         smp_weight_q <= '0;
         smp_type_q   <= '0;
         wr_index_q   <= '0;
         wr_value_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         sweeps_q     <= sweeps_d;
         sweep_cnt_q  <= sweep_cnt_d;
         skip_cnt_q   <= skip_cnt_d;
         smp_from_q   <= smp_from_d;
         smp_to_q     <= smp_to_d;
         smp_weight_q <= smp_weight_d;
         smp_type_q   <= smp_type_d;
         wr_index_q   <= wr_index_d;
         wr_value_q   <= wr_value_d;
      end
   end

   // Next-state logic and strobes; abort wins over every other event.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      sweeps_d     = sweeps_q;
      sweep_cnt_d  = sweep_cnt_q;
      skip_cnt_d   = skip_cnt_q;
      smp_from_d   = smp_from_q;
      smp_to_d     = smp_to_q;
      smp_weight_d = smp_weight_q;
      smp_type_d   = smp_type_q;
      wr_index_d   = wr_index_q;
      wr_value_d   = wr_value_q;
      out_seg_req    = 1'b0;
      out_smp_enable = 1'b0;
      out_wr_en      = 1'b0;
      out_done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_start) begin
               if (in_num_sweeps == 8'd0) begin
                  state_d = StDone;
               end else begin
                  sweeps_d    = in_num_sweeps;
                  idx_d       = '0;
                  sweep_cnt_d = '0;
                  skip_cnt_d  = '0;
                  state_d     = StReq;
               end
            end
         end
         StReq: begin
            out_seg_req = 1'b1;
            if (in_abort) begin
               state_d = StIdle;
            end else if (in_seg_valid) begin
               if (in_seg_type != 2'd0) begin
                  smp_from_d   = in_seg_from;
                  smp_to_d     = in_seg_to;
                  smp_weight_d = in_seg_weight;
                  smp_type_d   = in_seg_type;
                  cnt_d        = LatInit;
                  state_d      = StDrive;
               end else begin
                  // Invalid segment: count it and move on without a write.
                  if (skip_cnt_q != 8'hff) begin
                     skip_cnt_d = skip_cnt_q + 8'd1;
                  end
                  idx_d   = idx_next;
                  if (last_var) begin
                     sweep_cnt_d = sweep_next;
                  end
                  state_d = adv_state;
               end
            end
         end
         StDrive: begin
            out_smp_enable = 1'b1;
            if (in_abort) begin
               state_d = StIdle;
            end else if (cnt_q <= CntW'(1)) begin
               cnt_d      = '0;
               wr_value_d = in_smp_value;
               wr_index_d = idx_q;
               state_d    = StWrite;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StWrite: begin
            out_wr_en = !in_abort;
            if (in_abort) begin
               state_d = StIdle;
            end else begin
               idx_d = idx_next;
               if (last_var) begin
                  sweep_cnt_d = sweep_next;
               end
               state_d = adv_state;
            end
         end
         StDone: begin
            out_done = !in_abort;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign out_busy          = (state_q != StIdle);
   assign out_seg_var_index = idx_q;
   assign out_smp_from      = smp_from_q;
   assign out_smp_to        = smp_to_q;
   assign out_smp_weight    = smp_weight_q;
   assign out_smp_type      = smp_type_q;
   assign out_wr_index      = wr_index_q;
   assign out_wr_value      = wr_value_q;
   assign out_sweep_count   = sweep_cnt_q;
   assign out_skip_count    = skip_cnt_q;

endmodule
